// File: rtl/key_tracker_if.sv
// key_tracker_if: scan-code input stream and lane-state outputs of key_tracker.
// The keyboard side drives the master modport; key_tracker uses the slave modport.
interface key_tracker_if;
    logic       code_valid;
    logic [7:0] code;
    logic       frame_start;
    logic [7:0] key_now;
    logic [7:0] keyTrack;
    logic [7:0] hit;
    logic       unknown_code;

    modport master (
        output code_valid, code, frame_start,
        input  key_now, keyTrack, hit, unknown_code
    );

    modport slave (
        input  code_valid, code, frame_start,
        output key_now, keyTrack, hit, unknown_code
    );
endinterface

// File: rtl/key_tracker.sv
// key_tracker: PS/2 set-2 scan-code decoder producing 8 lane states,
// a frame-synchronised copy for the renderer, and per-lane press pulses.
// Optional stuck-key auto-release is enabled by defining KEY_TRACKER_TIMEOUT_EN.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for a make code or a prefix
// BRK     | F0 seen; next byte is a break code
// EXT     | E0 seen; next byte belongs to an extended key
// EXT_BRK | E0 F0 seen; next byte is an extended break, ignored
module key_tracker #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input logic          Clk,
    input logic          Reset,
    key_tracker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 26)) begin : g_param_check
        $error("key_tracker: TIMEOUT_CYCLES must be in 2..2**26");
    end

    state_t     state, state_nxt;
    logic [7:0] set_mask, clr_mask, to_mask;
    logic       unk_nxt;
    logic [7:0] key_r, track_r, hit_r;
    logic       unk_r;
    logic [7:0] code_mask;

    // One-hot lane for a mapped make/break byte, zero when unmapped.
    function automatic logic [7:0] lane_mask(input logic [7:0] c);
        case (c)
            8'h1C:   lane_mask = 8'h80;
            8'h1B:   lane_mask = 8'h40;
            8'h23:   lane_mask = 8'h20;
            8'h2B:   lane_mask = 8'h10;
            8'h3B:   lane_mask = 8'h08;
            8'h42:   lane_mask = 8'h04;
            8'h4B:   lane_mask = 8'h02;
            8'h4C:   lane_mask = 8'h01;
            default: lane_mask = 8'h00;
        endcase
    endfunction

    assign code_mask = lane_mask(bus.code);

    // Decoder state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and per-byte lane set/clear decisions.
    always_comb begin
        state_nxt = state;
        set_mask  = 8'h00;
        clr_mask  = 8'h00;
        unk_nxt   = 1'b0;
        if (bus.code_valid) begin
            case (state)
                IDLE: begin
                    if (bus.code == CODE_BRK)      state_nxt = BRK;
                    else if (bus.code == CODE_EXT) state_nxt = EXT;
                    else if (code_mask != 8'h00)   set_mask  = code_mask;
                    else                           unk_nxt   = 1'b1;
                end
                BRK: begin
                    // Prefix bytes here are plain unmapped data.
                    if (code_mask != 8'h00) clr_mask = code_mask;
                    else                    unk_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                EXT: begin
                    if (bus.code == CODE_BRK) state_nxt = EXT_BRK;
                    else                      state_nxt = IDLE;
                end
                EXT_BRK: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef KEY_TRACKER_TIMEOUT_EN
    localparam logic [25:0] TO_LAST = 26'(TIMEOUT_CYCLES - 1);

    for (genvar i = 0; i < 8; i++) begin : g_timeout
        logic [25:0] cnt_q;

        // Per-lane hold timer; restarts on every make, idles while the lane is clear.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset)
                cnt_q <= 26'd0;
            else if (set_mask[i] || !key_r[i] || cnt_q == TO_LAST)
                cnt_q <= 26'd0;
            else
                cnt_q <= cnt_q + 26'd1;
        end

        // A make on the expiry cycle keeps the lane set.
        assign to_mask[i] = key_r[i] && (cnt_q == TO_LAST) && !set_mask[i];
    end
`else
    assign to_mask = 8'h00;
`endif

    // Live lane state, press pulses, unknown-code pulse and frame-latched copy.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            key_r   <= 8'h00;
            track_r <= 8'h00;
            hit_r   <= 8'h00;
            unk_r   <= 1'b0;
        end else begin
            key_r <= (key_r | set_mask) & ~clr_mask & ~to_mask;
            hit_r <= set_mask & ~key_r;
            unk_r <= unk_nxt;
            if (bus.frame_start) track_r <= key_r;
        end
    end

    assign bus.key_now      = key_r;
    assign bus.keyTrack     = track_r;
    assign bus.hit          = hit_r;
    assign bus.unknown_code = unk_r;
endmodule

// File: tb/tb_key_tracker.sv
// tb_key_tracker: directed vector table plus hand-written corner sequences for key_tracker.
module tb_key_tracker;
    logic Clk = 1'b0;
    logic Reset;

    key_tracker_if bus ();

    key_tracker #(.TIMEOUT_CYCLES(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       cv;
        logic [7:0] code;
        logic       fs;
        logic [7:0] exp_key;
        logic [7:0] exp_trk;
        logic [7:0] exp_hit;
        logic       exp_unk;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic cv, input logic [7:0] code, input logic fs,
                                input logic [7:0] k, input logic [7:0] t,
                                input logic [7:0] h, input logic u);
        vec_t v;
        v.cv = cv; v.code = code; v.fs = fs;
        v.exp_key = k; v.exp_trk = t; v.exp_hit = h; v.exp_unk = u;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] k, input logic [7:0] t,
                             input logic [7:0] h, input logic u);
        check({tag, " key_now"}, bus.key_now, k);
        check({tag, " keyTrack"}, bus.keyTrack, t);
        check({tag, " hit"}, bus.hit, h);
        check({tag, " unknown_code"}, {7'd0, bus.unknown_code}, {7'd0, u});
    endtask

    // Drive one byte at the falling edge; result sampled at the next falling edge.
    task automatic send(input logic [7:0] c);
        bus.code_valid = 1'b1;
        bus.code       = c;
        @(negedge Clk);
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;
    endtask

    task automatic idle_cycle();
        bus.code_valid  = 1'b0;
        bus.frame_start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        int cnt;
        bus.code_valid  = 1'b0;
        bus.code        = 8'h00;
        bus.frame_start = 1'b0;
        Reset           = 1'b1;

        //          cv  code   fs  key    trk    hit    unk
        vecs.push_back(mk(1, 8'h1C, 0, 8'h80, 8'h00, 8'h80, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h80, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 8'h80, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 8'h80, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 8'h80, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h80, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 8'h00, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 8'h00, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h4A, 0, 8'h00, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 8'h00, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h00, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h4C, 0, 8'h00, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h4C, 0, 8'h01, 8'h80, 8'h01, 0));
        vecs.push_back(mk(1, 8'h29, 0, 8'h01, 8'h80, 8'h00, 1));
        vecs.push_back(mk(0, 8'h00, 0, 8'h01, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h01, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h3B, 0, 8'h01, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h01, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 8'h01, 8'h80, 8'h00, 1));
        vecs.push_back(mk(1, 8'h1C, 0, 8'h81, 8'h80, 8'h80, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 8'h81, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 8'h81, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h4B, 0, 8'h83, 8'h80, 8'h02, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h83, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h1C, 0, 8'h03, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h03, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h4B, 0, 8'h01, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h01, 8'h80, 8'h00, 0));
        vecs.push_back(mk(1, 8'h4C, 0, 8'h00, 8'h80, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk(1, 8'h42, 1, 8'h04, 8'h00, 8'h04, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h04, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 8'h04, 8'h04, 8'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 8'h04, 8'h04, 8'h00, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h04, 8'h04, 8'h00, 0));
        vecs.push_back(mk(1, 8'hE0, 0, 8'h04, 8'h04, 8'h00, 0));
        vecs.push_back(mk(1, 8'h4C, 0, 8'h05, 8'h04, 8'h01, 0));

        repeat (2) @(negedge Clk);
        check_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);

        foreach (vecs[i]) begin
            bus.code_valid  = vecs[i].cv;
            bus.code        = vecs[i].code;
            bus.frame_start = vecs[i].fs;
            @(negedge Clk);
            check_all($sformatf("vec%0d", i), vecs[i].exp_key, vecs[i].exp_trk,
                      vecs[i].exp_hit, vecs[i].exp_unk);
        end
        idle_cycle();

        // Reset between F0 and 2B: prefix is dropped, 2B is a make.
        send(8'hF0);
        #2 Reset = 1'b1;
        #1 check_all("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        send(8'h2B);
        check_all("after_reset_2B", 8'h10, 8'h00, 8'h10, 1'b0);
        idle_cycle();
        check_all("after_reset_idle", 8'h10, 8'h00, 8'h00, 1'b0);

        do_reset();
`ifdef KEY_TRACKER_TIMEOUT_EN
        // Single make: lane 5 visible for exactly 16 cycles, single hit.
        send(8'h23);
        check("to_first_hit", bus.hit, 8'h20);
        cnt = (bus.key_now[5]) ? 1 : 0;
        for (int j = 1; j < 60; j++) begin
            idle_cycle();
            if (bus.hit != 8'h00) check("to_spurious_hit", bus.hit, 8'h00);
            if (!bus.key_now[5]) break;
            cnt++;
        end
        check("to_hold_cycles", 8'(cnt), 8'd16);
        check("to_cleared", bus.key_now, 8'h00);

        // Repeat make 10 cycles later pushes the release out by 10.
        idle_cycle();
        send(8'h23);
        cnt = (bus.key_now[5]) ? 1 : 0;
        for (int j = 1; j < 80; j++) begin
            if (j == 10) send(8'h23);
            else         idle_cycle();
            if (bus.hit != 8'h00) check("to_repeat_hit", bus.hit, 8'h00);
            if (!bus.key_now[5]) break;
            cnt++;
        end
        check("to_repeat_hold", 8'(cnt), 8'd26);
        check("to_repeat_cleared", bus.key_now, 8'h00);
`else
        // Without auto-release the lane holds indefinitely.
        send(8'h23);
        check("hold_hit", bus.hit, 8'h20);
        repeat (40) idle_cycle();
        check("hold_key", bus.key_now, 8'h20);
        check("hold_no_hit", bus.hit, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
